result_uart_tx: RTL and testbench

RESULT_UART_TX -- requirements
Module: result_uart_tx

---
 rtl/result_uart_tx.sv | 158 +++++++++++++++
 tb/tb_result_uart_tx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/result_uart_tx.sv
// result_uart_tx: reports a 16-bit result word over a UART line as four
// uppercase ASCII hex digits (MSB nibble first) followed by CR LF, 8N1.
//
// Ports:
//   clk      - system clock, all state updates on its rising edge
//   reset_n  - asynchronous active-low reset
//   data_in  - result word to report, captured when send is accepted
//   send     - transmit request, level-sampled, accepted only while idle
//   busy     - high while a frame is on the line
//   done     - one-cycle pulse after the last stop bit of a frame
//   tx       - registered UART serial output, idles high
module result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] data_in,
  input  logic        send,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int unsigned BAUD_W  = 16;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam logic [2:0]  LAST_BYTE = 3'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [2:0]        byte_q, byte_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [BYTE_W-1:0] cur_byte_c;
  logic              bit_end_c;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // Byte currently being serialised, selected by byte index.
  always_comb begin
    case (byte_q)
      3'd0:    cur_byte_c = hex_ascii(word_q[15:12]);
      3'd1:    cur_byte_c = hex_ascii(word_q[11:8]);
      3'd2:    cur_byte_c = hex_ascii(word_q[7:4]);
      3'd3:    cur_byte_c = hex_ascii(word_q[3:0]);
      3'd4:    cur_byte_c = 8'h0D;
      default: cur_byte_c = 8'h0A;
    endcase
  end

  assign bit_end_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // Next-state and output logic; tx_d is the level for the next bit period.
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end_c ? '0 : baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (send && !busy_q) begin
          word_d  = data_in;
          state_d = ST_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          byte_d  = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = cur_byte_c[0];
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte_c[3'(bit_q + 3'd1)];
          end
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          if (byte_q == LAST_BYTE) begin
            state_d = ST_IDLE;
            byte_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            byte_d  = byte_q + 3'd1;
            state_d = ST_START;
            tx_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State register; reset aborts any frame with the line high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx at CLKS_PER_BIT=4: table-driven frames
// plus hand-written sequences for held send, mid-frame send and reset.
module tb_result_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int          FRAME = 60 * CPB;
  localparam int          NONE  = -10;

  logic        clk;
  logic        reset_n;
  logic [15:0] data_in;
  logic        send;
  logic        busy;
  logic        done;
  logic        tx;

  int n_cmp = 0;
  int n_err = 0;

  result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .data_in (data_in),
    .send    (send),
    .busy    (busy),
    .done    (done),
    .tx      (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [47:0] exp;   // expected six bytes, first byte in the MSBs
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Line must stay idle (tx high, not busy, no done) for n cycles.
  task automatic idle_check(input string name, input int n);
    int bad = 0;
    for (int c = 0; c < n; c++) begin
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    chk(name, 64'(bad), 64'd0);
  endtask

  // Request a frame; returns at the negedge of the first start-bit cycle.
  task automatic send_pulse(input logic [15:0] w);
    send    = 1'b1;
    data_in = w;
    @(negedge clk);
    send    = 1'b0;
  endtask

  // Called at the negedge of the first start-bit cycle; records the whole
  // frame, decodes it, and checks the done cycle. Optionally changes
  // data_in and/or pulses send at given cycles of the frame.
  task automatic check_frame(input string tag, input logic [47:0] exp,
                             input int chg_at, input logic [15:0] chg_data,
                             input int pulse_at, input logic [15:0] pulse_data);
    logic       b [FRAME];
    int         busy_bad = 0;
    int         done_bad = 0;
    int         tim_bad  = 0;
    logic [7:0] got;
    for (int c = 0; c < FRAME; c++) begin
      b[c] = tx;
      if (busy !== 1'b1) busy_bad++;
      if (done !== 1'b0) done_bad++;
      if (c == chg_at) data_in = chg_data;
      if (c == pulse_at) begin
        send    = 1'b1;
        data_in = pulse_data;
      end
      if (c == pulse_at + 1) send = 1'b0;
      @(negedge clk);
    end
    for (int j = 0; j < 6; j++) begin
      for (int p = 0; p < 10; p++)
        for (int k = 1; k < CPB; k++)
          if (b[j*40 + p*4 + k] !== b[j*40 + p*4]) tim_bad++;
      if (b[j*40] !== 1'b0) tim_bad++;
      if (b[j*40 + 36] !== 1'b1) tim_bad++;
      got = '0;
      for (int i = 0; i < 8; i++) got[i] = b[j*40 + 4 + i*4];
      chk($sformatf("%s byte%0d", tag, j), 64'(got), 64'(exp[47 - 8*j -: 8]));
    end
    chk({tag, " bit timing/framing errors"}, 64'(tim_bad), 64'd0);
    chk({tag, " busy low inside frame"}, 64'(busy_bad), 64'd0);
    chk({tag, " done inside frame"}, 64'(done_bad), 64'd0);
    chk({tag, " done at 60*CPB"}, 64'(done), 64'd1);
    chk({tag, " busy in done cycle"}, 64'(busy), 64'd0);
    chk({tag, " tx in done cycle"}, 64'(tx), 64'd1);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{16'h1A2F, 48'h3141_3246_0D0A};
    vecs[1] = '{16'h0000, 48'h3030_3030_0D0A};
    vecs[2] = '{16'hFFFF, 48'h4646_4646_0D0A};
    vecs[3] = '{16'h9B5E, 48'h3942_3545_0D0A};
    vecs[4] = '{16'h00C3, 48'h3030_4333_0D0A};

    reset_n = 1'b0;
    send    = 1'b0;
    data_in = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset tx",   64'(tx),   64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    reset_n = 1'b1;
    idle_check("idle after reset", 10);

    // Table-driven frames.
    for (int v = 0; v < 5; v++) begin
      send_pulse(vecs[v].word);
      check_frame($sformatf("vec%0d", v), vecs[v].exp, NONE, 16'h0, NONE, 16'h0);
      @(negedge clk);
      idle_check($sformatf("vec%0d idle after", v), 8);
    end

    // send held high: back-to-back frames; data change mid-frame is ignored
    // by frame 1 and captured by frame 2 at the done cycle.
    send    = 1'b1;
    data_in = 16'h1234;
    @(negedge clk);
    check_frame("held f1", 48'h3132_3334_0D0A, 100, 16'hABCD, NONE, 16'h0);
    @(negedge clk);
    send = 1'b0;
    chk("held f2 starts cycle after done", 64'(tx), 64'd0);
    check_frame("held f2", 48'h4142_4344_0D0A, NONE, 16'h0, NONE, 16'h0);
    @(negedge clk);
    idle_check("held no third frame", 20);

    // send pulse at cycle 100 of a frame with different data: ignored.
    send_pulse(16'h7E01);
    check_frame("midsend", 48'h3745_3031_0D0A, NONE, 16'h0, 100, 16'h5555);
    @(negedge clk);
    idle_check("midsend no extra frame", 3 * FRAME / 2);

    // Reset during byte 2 DATA state.
    send_pulse(16'h5A5A);
    repeat (90) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort tx",   64'(tx),   64'd1);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    @(negedge clk);
    idle_check("held in reset", 10);
    reset_n = 1'b1;
    idle_check("idle after abort", 10);
    send_pulse(16'h00C3);
    check_frame("post-reset", 48'h3030_4333_0D0A, NONE, 16'h0, NONE, 16'h0);
    @(negedge clk);
    idle_check("post-reset idle", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
